// File: rtl/pixel_word_packer.sv
// Packs 8-bit pixels four per 32-bit word, little-endian, onto a memory write port; strobe 1 cycle after the completing pixel.
// Ready is high throughout PACK (sustained 1 pixel/cycle, no bubbles); define PACKER_STATS_EN to add the o_words_written counter.
module pixel_word_packer #(
   parameter int ADDR_W    = 16,
   parameter int ADDR_STEP = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic              i_pix_valid,
   output logic              o_pix_ready,
   input  logic [7:0]        i_pix_data,
   input  logic              i_pix_last,
   output logic              o_mem_we,
   output logic [3:0]        o_mem_byte_en,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_wdata,
   output logic              o_done
`ifdef PACKER_STATS_EN
   ,
   output logic [15:0]       o_words_written
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PACK  = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [1:0]        lane_q, lane_d;
   logic [31:0]       acc_q, acc_d;
   logic [3:0]        be_q, be_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              done_q, done_d;

   logic              hs;
   logic              start_acc;
   logic [31:0]       word;
   logic [3:0]        word_be;
   logic [1:0]        unused_base_lsbs;

   assign unused_base_lsbs = i_base_addr[1:0];
   assign hs        = i_pix_valid && (state_q == S_PACK);
   assign start_acc = i_start && ((state_q == S_IDLE) || (state_q == S_DONE));

   always_comb begin
      state_d     = state_q;
      lane_d      = lane_q;
      acc_d       = acc_q;
      be_d        = be_q;
      addr_d      = addr_q;
      we_d        = 1'b0;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      done_d      = done_q;
      word        = acc_q;
      word[{lane_q, 3'b000} +: 8] = i_pix_data;
      word_be     = be_q | (4'b0001 << lane_q);

      case (state_q)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               addr_d  = {i_base_addr[ADDR_W-1:2], 2'b00};
               lane_d  = 2'd0;
               acc_d   = 32'd0;
               be_d    = 4'd0;
               done_d  = 1'b0;
               state_d = S_PACK;
            end
         end
         S_PACK: begin
            if (hs) begin
               if ((lane_q == 2'd3) || i_pix_last) begin
                  // Completing pixel goes straight to the output regs so the accumulator is free next cycle.
                  we_d        = 1'b1;
                  mem_wdata_d = word;
                  mem_be_d    = word_be;
                  mem_addr_d  = addr_q;
                  addr_d      = addr_q + ADDR_W'(ADDR_STEP);
                  acc_d       = 32'd0;
                  be_d        = 4'd0;
                  lane_d      = 2'd0;
               end else begin
                  acc_d  = word;
                  be_d   = word_be;
                  lane_d = lane_q + 2'd1;
               end
               if (i_pix_last) begin
                  state_d = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            state_d = S_DONE;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         lane_q      <= 2'd0;
         acc_q       <= 32'd0;
         be_q        <= 4'd0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         mem_be_q    <= 4'd0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'd0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         lane_q      <= lane_d;
         acc_q       <= acc_d;
         be_q        <= be_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         done_q      <= done_d;
      end
   end

   assign o_pix_ready   = (state_q == S_PACK);
   assign o_mem_we      = we_q;
   assign o_mem_byte_en = mem_be_q;
   assign o_mem_addr    = mem_addr_q;
   assign o_mem_wdata   = mem_wdata_q;
   assign o_done        = done_q;

`ifdef PACKER_STATS_EN
   logic [15:0] cnt_q, cnt_d;

   // Counts alongside the strobe so the value is current in the same cycle as o_mem_we.
   always_comb begin
      cnt_d = cnt_q;
      if (start_acc) begin
         cnt_d = 16'd0;
      end else if (we_d && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_words_written = cnt_q;
`else
   logic unused_start_acc;
   assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_pixel_word_packer.sv
// Self-checking bench for pixel_word_packer: directed frames plus random frames against a word-level reference model.
module tb_pixel_word_packer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [15:0] i_base_addr = 16'd0;
   logic        i_pix_valid = 1'b0;
   logic [7:0]  i_pix_data = 8'd0;
   logic        i_pix_last = 1'b0;
   logic        o_pix_ready;
   logic        o_mem_we;
   logic [3:0]  o_mem_byte_en;
   logic [15:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic        o_done;
`ifdef PACKER_STATS_EN
   logic [15:0] o_words_written;
`endif

   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      int          cyc;
   } wr_t;

   wr_t got_q[$];
   int  hs_q[$];
   int  cyc = 0;
   int  n_cmp = 0;
   int  n_fail = 0;

   pixel_word_packer #(.ADDR_W(16), .ADDR_STEP(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_start        (i_start),
      .i_base_addr    (i_base_addr),
      .i_pix_valid    (i_pix_valid),
      .o_pix_ready    (o_pix_ready),
      .i_pix_data     (i_pix_data),
      .i_pix_last     (i_pix_last),
      .o_mem_we       (o_mem_we),
      .o_mem_byte_en  (o_mem_byte_en),
      .o_mem_addr     (o_mem_addr),
      .o_mem_wdata    (o_mem_wdata),
      .o_done         (o_done)
`ifdef PACKER_STATS_EN
      ,
      .o_words_written(o_words_written)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Every cycle with the strobe high is logged, so a stretched strobe shows up as an extra write.
   always @(negedge clk) begin
      if (o_mem_we === 1'b1) begin
         got_q.push_back('{o_mem_addr, o_mem_wdata, o_mem_byte_en, cyc});
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [15:0] base);
      i_base_addr = base;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      i_base_addr = 16'($urandom);
      hs_q.delete();
      check("ready_in_pack", {63'd0, o_pix_ready}, 64'd1);
      check("done_cleared", {63'd0, o_done}, 64'd0);
   endtask

   task automatic send_pix(input logic [7:0] d, input bit last, input bit gaps);
      if (gaps) begin
         repeat ($urandom_range(0, 2)) tick();
      end
      i_pix_valid = 1'b1;
      i_pix_data  = d;
      i_pix_last  = last;
      hs_q.push_back(cyc);
      tick();
      i_pix_valid = 1'b0;
      i_pix_last  = 1'b0;
      i_pix_data  = 8'($urandom);
   endtask

   task automatic wait_done(output int dcyc);
      int t = 0;
      while (o_done !== 1'b1 && t < 20) begin
         tick();
         t++;
      end
      check("done_seen", {63'd0, o_done}, 64'd1);
      dcyc = cyc;
   endtask

   // Reference: split the pixel list into 4-byte groups; each group is one little-endian word at base+4*w.
   task automatic check_frame(input logic [15:0] base, input logic [7:0] px[$], input int first, input int dcyc);
      int          n;
      int          nw;
      int          li;
      logic [31:0] w_exp;
      logic [3:0]  be_exp;
      logic [15:0] a_exp;
      n  = px.size();
      nw = (n + 3) / 4;
      w_exp = 32'd0;
      repeat (3) tick();
      check("write_count", 64'(got_q.size() - first), 64'(nw));
      for (int w = 0; w < nw; w++) begin
         w_exp  = 32'd0;
         be_exp = 4'd0;
         for (int k = 0; k < 4; k++) begin
            if (4 * w + k < n) begin
               w_exp     = w_exp | (32'(px[4 * w + k]) << (8 * k));
               be_exp[k] = 1'b1;
            end
         end
         a_exp = (base & 16'hFFFC) + 16'(4 * w);
         li    = (4 * w + 3 < n) ? 4 * w + 3 : n - 1;
         if (first + w < got_q.size()) begin
            check("wr_addr", 64'(got_q[first + w].addr), 64'(a_exp));
            check("wr_data", 64'(got_q[first + w].data), 64'(w_exp));
            check("wr_be", 64'(got_q[first + w].be), 64'(be_exp));
            check("wr_latency", 64'(got_q[first + w].cyc), 64'(hs_q[li] + 1));
         end
      end
      check("done_after_strobe", 64'(dcyc), 64'(hs_q[n - 1] + 2));
      check("ready_low_done", {63'd0, o_pix_ready}, 64'd0);
      check("wdata_hold", 64'(o_mem_wdata), 64'(w_exp));
`ifdef PACKER_STATS_EN
      check("words_written", 64'(o_words_written), 64'(nw));
`endif
   endtask

   task automatic run_frame(input logic [15:0] base, input logic [7:0] px[$], input bit gaps);
      int first;
      int dcyc;
      first = got_q.size();
      start_frame(base);
      for (int k = 0; k < px.size(); k++) begin
         send_pix(px[k], k == px.size() - 1, gaps);
      end
      wait_done(dcyc);
      check_frame(base, px, first, dcyc);
   endtask

   initial begin
      logic [7:0] px[$];
      int         first;
      int         dcyc;
      int         len;

      #2;
      check("rst_we", {63'd0, o_mem_we}, 64'd0);
      check("rst_addr", 64'(o_mem_addr), 64'd0);
      check("rst_wdata", 64'(o_mem_wdata), 64'd0);
      check("rst_be", 64'(o_mem_byte_en), 64'd0);
      check("rst_done", {63'd0, o_done}, 64'd0);
      check("rst_ready", {63'd0, o_pix_ready}, 64'd0);
      tick();
      rst_n = 1'b1;

      // Valid while idle must be ignored.
      i_pix_valid = 1'b1;
      i_pix_data  = 8'h5A;
      i_pix_last  = 1'b1;
      tick();
      tick();
      i_pix_valid = 1'b0;
      i_pix_last  = 1'b0;
      check("idle_ready", {63'd0, o_pix_ready}, 64'd0);
      check("idle_no_write", 64'(got_q.size()), 64'd0);

      px = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      run_frame(16'h0100, px, 1'b0);
      px = '{8'hAA};
      run_frame(16'h0104, px, 1'b0);
      px = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
      run_frame(16'h0202, px, 1'b0);
      px = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      run_frame(16'h0300, px, 1'b1);
      px.delete();
      for (int k = 0; k < 8; k++) px.push_back(8'($urandom));
      run_frame(16'hFFFC, px, 1'b0);

      // Start pulse mid-frame must not disturb address or accumulator.
      first = got_q.size();
      start_frame(16'h0100);
      send_pix(8'h01, 1'b0, 1'b0);
      send_pix(8'h02, 1'b0, 1'b0);
      i_base_addr = 16'h0500;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      send_pix(8'h03, 1'b0, 1'b0);
      send_pix(8'h04, 1'b1, 1'b0);
      wait_done(dcyc);
      px = '{8'h01, 8'h02, 8'h03, 8'h04};
      check_frame(16'h0100, px, first, dcyc);

      // Reset in the middle of a partial word.
      first = got_q.size();
      start_frame(16'h0100);
      send_pix(8'hAA, 1'b0, 1'b0);
      send_pix(8'hBB, 1'b0, 1'b0);
      i_pix_valid = 1'b1;
      i_pix_data  = 8'hCC;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_we", {63'd0, o_mem_we}, 64'd0);
      check("arst_addr", 64'(o_mem_addr), 64'd0);
      check("arst_wdata", 64'(o_mem_wdata), 64'd0);
      check("arst_be", 64'(o_mem_byte_en), 64'd0);
      check("arst_done", {63'd0, o_done}, 64'd0);
      check("arst_ready", {63'd0, o_pix_ready}, 64'd0);
      i_pix_valid = 1'b0;
      repeat (3) tick();
      check("arst_no_write", 64'(got_q.size()), 64'(first));
      rst_n = 1'b1;
      tick();
      check("post_rst_idle", {63'd0, o_pix_ready}, 64'd0);

      for (int f = 0; f < 6; f++) begin
         px.delete();
         len = $urandom_range(1, 13);
         for (int k = 0; k < len; k++) px.push_back(8'($urandom));
         run_frame(16'($urandom), px, 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pixel_word_packer.md
Name: pixel_word_packer

Overview:
- Sits directly upstream of memory_interface in the downscaling datapath.
- Takes the 8-bit downscaled pixel stream and packs 4 pixels per 32-bit word, little-endian.
- Drives the memory write port (we, byte enables, address, wdata) starting from a per-frame base address.
- Flushes a partial final word using byte enables and signals frame completion.

Parameters:
- ADDR_W, 16, byte-address width of o_mem_addr; must match memory_interface.
- ADDR_STEP, 4, byte-address increment per written word.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  frame start pulse; honoured only in IDLE or DONE
- i_base_addr  in  ADDR_W  frame base byte address; bits [1:0] ignored (forced 0)
- i_pix_valid  in  1  pixel valid
- o_pix_ready  out  1  packer can accept a pixel
- i_pix_data  in  8  pixel value
- i_pix_last  in  1  marks final pixel of the frame; qualified by the valid&ready handshake
- o_mem_we  out  1  one-cycle write strobe
- o_mem_byte_en  out  4  lanes written; bit k covers wdata[8k+7:8k]
- o_mem_addr  out  ADDR_W  word-aligned write address
- o_mem_wdata  out  32  packed word; unfilled lanes are 0
- o_done  out  1  frame complete; held until the next accepted i_start
- o_words_written  out  16  present only with PACKER_STATS_EN

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: all outputs 0, state IDLE, lane index 0, accumulator 0.
- FSM states: IDLE, PACK, FLUSH, DONE.
- IDLE/DONE:
  - o_pix_ready=0.
  - i_start=1 -> latch {i_base_addr[ADDR_W-1:2],2'b00} into the address register, clear lane index and accumulator, clear o_done, go to PACK.
- PACK:
  - o_pix_ready=1 in every cycle.
  - A handshake (valid&ready) writes i_pix_data into lane = lane index and sets that lane's enable bit.
  - Lane index increments mod 4.
- Word complete: a handshake with lane index 3, or any handshake with i_pix_last=1.
  - Next cycle: o_mem_we=1 for exactly one cycle.
  - o_mem_wdata = accumulated word including the completing byte; unused lanes are 0.
  - o_mem_byte_en = filled lanes: 0001, 0011, 0111 or 1111.
  - o_mem_addr = current address register.
  - The address register then advances by ADDR_STEP, wrapping modulo 2^ADDR_W (0xFFFC -> 0x0000).
- Latency: one cycle from the completing handshake to the write strobe.
- Back-to-back words: a pixel accepted in the same cycle as the strobe goes into a fresh accumulator. No bubbles; sustained 1 pixel/cycle.
- i_pix_last handshake: go to FLUSH. The write strobe fires in FLUSH with o_pix_ready=0, then go to DONE with o_done=1 in the following cycle.
- Last on lane 3: exactly one write with byte_en=1111; no extra empty write.
- o_mem_addr, o_mem_wdata and o_mem_byte_en hold their last written values while we=0. Only o_mem_we pulses.
- i_start in PACK or FLUSH: ignored.
- i_pix_valid outside PACK: ignored, since ready is 0.
- Pixel data and last are sampled only on a handshake. Idle valid gaps do not advance the lane index.
- Reset mid-frame: immediate return to reset values. The partial word is discarded and no write is issued.

Optional Feature:
- Macro PACKER_STATS_EN.
- Defined:
  - o_words_written port exists.
  - 16-bit counter cleared on accepted i_start.
  - Incremented on every o_mem_we cycle; saturates at 0xFFFF.
  - Holds its value in DONE; reset to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- base 0x0100; pixels EF,BE,AD,DE with last on DE -> single write addr 0x0100, wdata 0xDEADBEEF, be 1111; o_done=1 the cycle after the strobe.
- base 0x0104; single pixel AA with last -> write addr 0x0104, wdata 0x000000AA, be 0001; no further writes.
- base 0x0202 (low bits forced 0); pixels 11..77 (7 bytes), last on 77 -> writes 0x44332211 @0x0200 be 1111, then 0x00776655 @0x0204 be 0111; o_words_written=2 with PACKER_STATS_EN.
- base 0x0300; 8 pixels with valid toggling 1,0,0,1 at random -> same words as gapless input (0x44332211 @0x0300, 0x88776655 @0x0304); each strobe exactly one cycle after its 4th handshake.
- base 0xFFFC; 8 pixels -> first write @0xFFFC, second @0x0000 (wrap).
- start base 0x0100, accept 2 pixels, pulse i_start with base 0x0500 -> ignored. Then assert rst_n=0 -> all outputs 0 asynchronously, no write, state IDLE, o_pix_ready=0.
